// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Optional early termination of the BUSY phase when MUL_SEQ_EARLY_EXIT_EN is defined.
module mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               en_i,
    output logic [2*WIDTH-1:0] data_o,
    output logic               valid_o,
    output logic               busy_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_step;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_SEQ_EARLY_EXIT_EN
                // Remaining multiplier bits all zero: further steps cannot change the sum.
                last_step = last_step || (mplier_d == '0);
`endif
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                data_d  = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and sampled here, so it overrides every transition above.
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);

endmodule
